// File: rtl/mux2_1_arb_pkg.sv
// Shared definitions for the 2:1 round-robin arbiter slice.
// Contents:
//   arb_state_e      : arbiter FSM state encoding (IDLE, GRANT0, GRANT1)
//   DEF_*            : default parameter values used by the modules
//   burst_cnt_width  : width needed for a burst counter that must reach max_burst
package mux2_1_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 2;
  localparam int DEF_MAX_BURST  = 4;
  localparam int DEF_CNT_WIDTH  = 8;

  // The counter has to hold the value max_burst itself, hence the +1.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux2_1_out_reg.sv
// Registered 2:1 mux with a single-entry valid/ready output stage.
// Ports:
//   clk       : clock, posedge
//   reset     : synchronous active-high reset, empties the stage
//   selector  : 0 loads data0, 1 loads data1
//   data0/1   : candidate lanes
//   push      : load the selected lane this cycle
//   pop       : downstream takes the held beat this cycle
//   data_out  : held beat
//   valid_out : stage holds a beat
module mux2_1_out_reg
  import mux2_1_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  selector,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;

  // Output stage: a push wins over a pop so push+pop reloads and stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (push) begin
      data_r  <= selector ? data1 : data0;
      valid_r <= 1'b1;
    end else if (pop) begin
      valid_r <= 1'b0;
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;

endmodule

// File: rtl/mux2_1_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered output lane between
// two valid/ready requesters, bounding each grant to MAX_BURST beats.
// Ports:
//   clk, reset              : clock (posedge) and synchronous active-high reset
//   valid_in0/data_in0      : requester 0 beat; ready_out0 accepts it
//   valid_in1/data_in1      : requester 1 beat; ready_out1 accepts it
//   data_out/valid_out      : registered output beat; ready_in takes it
//   selector                : 1 only while requester 1 holds the grant
//   busy                    : a grant is active
// Optional build macro MUX2_1_ARB_STATS_EN adds grant_cnt0/grant_cnt1,
// saturating counts of grant entries per requester.
module mux2_1_rr_arbiter
  import mux2_1_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
`ifdef MUX2_1_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in0,
  input  logic [DATA_WIDTH-1:0] data_in0,
  output logic                  ready_out0,
  input  logic                  valid_in1,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic                  ready_out1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  selector,
  output logic                  busy
`ifdef MUX2_1_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
`endif
);

  localparam int             BW         = burst_cnt_width(MAX_BURST);
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST);
  localparam logic [BW-1:0]  CNT_ZERO   = {BW{1'b0}};

  arb_state_e            state_r, state_nxt_s;
  logic                  last_served_r, last_served_nxt_s;
  logic [BW-1:0]         burst_cnt_r, burst_cnt_nxt_s, cnt_inc_s;
  logic                  slot_open_s, ready0_s, ready1_s;
  logic                  accept0_s, accept1_s, burst_done_s;
  logic                  push_s, pop_s, selector_s, valid_out_s;
  logic [DATA_WIDTH-1:0] data_out_s;

  // The output slot can take a beat when empty or being drained this cycle.
  assign slot_open_s  = !valid_out_s || ready_in;
  assign ready0_s     = (state_r == GRANT0) && slot_open_s;
  assign ready1_s     = (state_r == GRANT1) && slot_open_s;
  assign accept0_s    = valid_in0 && ready0_s;
  assign accept1_s    = valid_in1 && ready1_s;
  assign cnt_inc_s    = burst_cnt_r + BW'(1'b1);
  assign burst_done_s = (accept0_s || accept1_s) && (cnt_inc_s == BURST_LAST);
  assign push_s       = accept0_s || accept1_s;
  assign pop_s        = valid_out_s && ready_in;
  assign selector_s   = (state_r == GRANT1);

  // Next-state, burst counter and round-robin pointer.
  always_comb begin
    state_nxt_s       = state_r;
    last_served_nxt_s = last_served_r;
    burst_cnt_nxt_s   = burst_cnt_r;
    case (state_r)
      IDLE: begin
        burst_cnt_nxt_s = CNT_ZERO;
        if (valid_in0 && valid_in1) begin
          // last_served==1 means requester 0 is next in turn.
          state_nxt_s = last_served_r ? GRANT0 : GRANT1;
        end else if (valid_in0) begin
          state_nxt_s = GRANT0;
        end else if (valid_in1) begin
          state_nxt_s = GRANT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT0: begin
        if (burst_done_s) begin
          last_served_nxt_s = 1'b0;
          burst_cnt_nxt_s   = CNT_ZERO;
          if (valid_in1) begin
            state_nxt_s = GRANT1;
          end else if (valid_in0) begin
            state_nxt_s = GRANT0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (ready0_s && !valid_in0) begin
          // Offered slot went unused: hand over early.
          last_served_nxt_s = 1'b0;
          burst_cnt_nxt_s   = CNT_ZERO;
          state_nxt_s       = valid_in1 ? GRANT1 : IDLE;
        end else if (accept0_s) begin
          burst_cnt_nxt_s = cnt_inc_s;
        end else begin
          burst_cnt_nxt_s = burst_cnt_r;
        end
      end
      GRANT1: begin
        if (burst_done_s) begin
          last_served_nxt_s = 1'b1;
          burst_cnt_nxt_s   = CNT_ZERO;
          if (valid_in0) begin
            state_nxt_s = GRANT0;
          end else if (valid_in1) begin
            state_nxt_s = GRANT1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (ready1_s && !valid_in1) begin
          last_served_nxt_s = 1'b1;
          burst_cnt_nxt_s   = CNT_ZERO;
          state_nxt_s       = valid_in0 ? GRANT0 : IDLE;
        end else if (accept1_s) begin
          burst_cnt_nxt_s = cnt_inc_s;
        end else begin
          burst_cnt_nxt_s = burst_cnt_r;
        end
      end
      default: begin
        state_nxt_s       = IDLE;
        last_served_nxt_s = 1'b1;
        burst_cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
      burst_cnt_r   <= CNT_ZERO;
    end else begin
      state_r       <= state_nxt_s;
      last_served_r <= last_served_nxt_s;
      burst_cnt_r   <= burst_cnt_nxt_s;
    end
  end

  mux2_1_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .selector  (selector_s),
    .data0     (data_in0),
    .data1     (data_in1),
    .push      (push_s),
    .pop       (pop_s),
    .data_out  (data_out_s),
    .valid_out (valid_out_s)
  );

  assign ready_out0 = ready0_s;
  assign ready_out1 = ready1_s;
  assign data_out   = data_out_s;
  assign valid_out  = valid_out_s;
  assign selector   = selector_s;
  assign busy       = (state_r != IDLE);

`ifdef MUX2_1_ARB_STATS_EN
  localparam logic [CNT_WIDTH-1:0] STAT_MAX = {CNT_WIDTH{1'b1}};

  logic                 enter0_s, enter1_s;
  logic [CNT_WIDTH-1:0] grant_cnt0_r, grant_cnt1_r;

  // A grant entry is a move into GRANTx or a burst restart within GRANTx.
  assign enter0_s = (state_nxt_s == GRANT0) && ((state_r != GRANT0) || burst_done_s);
  assign enter1_s = (state_nxt_s == GRANT1) && ((state_r != GRANT1) || burst_done_s);

  // Saturating grant-entry counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_r <= {CNT_WIDTH{1'b0}};
      grant_cnt1_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (enter0_s && (grant_cnt0_r != STAT_MAX)) begin
        grant_cnt0_r <= grant_cnt0_r + CNT_WIDTH'(1'b1);
      end
      if (enter1_s && (grant_cnt1_r != STAT_MAX)) begin
        grant_cnt1_r <= grant_cnt1_r + CNT_WIDTH'(1'b1);
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_r;
  assign grant_cnt1 = grant_cnt1_r;
`endif

endmodule

// File: tb/tb_mux2_1_rr_arbiter.sv
// Self-checking bench for mux2_1_rr_arbiter: queue-driven requesters, a
// scoreboard of expected output beats, and one task per scenario.
module tb_mux2_1_rr_arbiter;

  localparam int DW = 2;
  localparam int MB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in0, valid_in1, ready_out0, ready_out1;
  logic [DW-1:0] data_in0, data_in1, data_out;
  logic          valid_out, ready_in, selector, busy;
`ifdef MUX2_1_ARB_STATS_EN
  logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] src0[$];
  logic [DW-1:0] src1[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mux2_1_rr_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
`ifdef MUX2_1_ARB_STATS_EN
    ,
    .CNT_WIDTH  (CW)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in0  (valid_in0),
    .data_in0   (data_in0),
    .ready_out0 (ready_out0),
    .valid_in1  (valid_in1),
    .data_in1   (data_in1),
    .ready_out1 (ready_out1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .selector   (selector),
    .busy       (busy)
`ifdef MUX2_1_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Upstream must hold valid and data until accepted.
  a_hold0: assert property (@(posedge clk) disable iff (reset)
    (valid_in0 && !ready_out0) |=> (valid_in0 && $stable(data_in0)))
    else $error("FAIL upstream_hold0: requester 0 changed before accept");
  a_hold1: assert property (@(posedge clk) disable iff (reset)
    (valid_in1 && !ready_out1) |=> (valid_in1 && $stable(data_in1)))
    else $error("FAIL upstream_hold1: requester 1 changed before accept");

  // Requester drivers: present the head of each source queue, pop on accept.
  initial begin
    bit            acc0, acc1;
    logic [DW-1:0] tmp;
    acc0 = 1'b0; acc1 = 1'b0;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = 2'b00; data_in1 = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (acc0 && src0.size() > 0) tmp = src0.pop_front();
      if (acc1 && src1.size() > 0) tmp = src1.pop_front();
      valid_in0 = (src0.size() > 0);
      data_in0  = valid_in0 ? src0[0] : 2'b00;
      valid_in1 = (src1.size() > 0);
      data_in1  = valid_in1 ? src1[0] : 2'b00;
      @(negedge clk);
      acc0 = valid_in0 && ready_out0 && !reset;
      acc1 = valid_in1 && ready_out1 && !reset;
    end
  end

  // Scoreboard: every downstream transfer must match the next expected beat.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && valid_out && ready_in) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_extra: data_out=%b transferred, nothing expected", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_err++;
            $display("FAIL scoreboard_data: data_out=%b expected %b", data_out, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready_in = 1'b1;
    src0.push_back(2'b11);
    step(); step();
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_vec++; if (data_out !== 2'b00) begin n_err++; $display("FAIL reset_data_out: got %b want 00", data_out); end
    n_vec++; if ({ready_out0, ready_out1} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b%b want 00", ready_out0, ready_out1); end
    n_vec++; if (selector !== 1'b0) begin n_err++; $display("FAIL reset_selector: got %b want 0", selector); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    src0.delete();
    step();
    reset = 1'b0;
`ifdef MUX2_1_ARB_STATS_EN
    n_vec++; if ({grant_cnt0, grant_cnt1} !== {CW{2'b00}}) begin n_err++; $display("FAIL reset_stats: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
`endif
  endtask

  task automatic test_single();
    logic       ev[5];
    logic       eb[5];
    logic [1:0] ed[5];
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ed = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    foreach (ed[i]) if (i >= 2) begin src0.push_back(ed[i]); exp_q.push_back(ed[i]); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if (valid_out !== ev[k]) begin n_err++; $display("FAIL single_valid c%0d: got %b want %b", k, valid_out, ev[k]); end
      n_vec++; if (busy !== eb[k]) begin n_err++; $display("FAIL single_busy c%0d: got %b want %b", k, busy, eb[k]); end
      n_vec++; if (selector !== 1'b0) begin n_err++; $display("FAIL single_selector c%0d: got %b want 0", k, selector); end
      if (ev[k]) begin
        n_vec++; if (data_out !== ed[k]) begin n_err++; $display("FAIL single_data c%0d: got %b want %b", k, data_out, ed[k]); end
      end
    end
    step(); step(); step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: busy=%b want 0", busy); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: %0d beats missing, want 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    logic exp_sel;
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < MB; b++) begin src0.push_back(2'b01); src1.push_back(2'b10); end
      for (int b = 0; b < MB; b++) exp_q.push_back(2'b01);
      for (int b = 0; b < MB; b++) exp_q.push_back(2'b10);
    end
    step(); step();
    n_vec++; if ({busy, selector} !== 2'b10) begin n_err++; $display("FAIL contention_first_grant: busy/sel=%b%b want 10", busy, selector); end
    for (int k = 2; k < 18; k++) begin
      step();
      exp_sel = (k >= 17) ? 1'b1 : (((k - 1) / MB) % 2 == 1);
      n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL contention_bubble c%0d: valid_out=%b want 1", k, valid_out); end
      n_vec++; if (selector !== exp_sel) begin n_err++; $display("FAIL contention_selector c%0d: got %b want %b", k, selector, exp_sel); end
    end
    step(); step(); step();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL contention_drain: %0d beats missing, want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [1:0] d0[6];
    d0 = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
    pulse_reset();
    foreach (d0[i]) src0.push_back(d0[i]);
    src1.push_back(2'b11);
    for (int i = 0; i < 4; i++) exp_q.push_back(d0[i]);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    for (int k = 0; k <= 12; k++) begin
      step();
      if (k == 2) begin
        n_vec++; if (data_out !== 2'b01) begin n_err++; $display("FAIL bp_first: got %b want 01", data_out); end
      end
      if (k >= 4 && k <= 6) begin
        n_vec++; if ({valid_out, data_out} !== 3'b110) begin n_err++; $display("FAIL bp_hold c%0d: v/d=%b/%b want 1/10", k, valid_out, data_out); end
        n_vec++; if ({ready_out0, busy, selector} !== 3'b010) begin n_err++; $display("FAIL bp_ctrl c%0d: rdy0/busy/sel=%b%b%b want 010", k, ready_out0, busy, selector); end
      end
      if (k == 7) begin
        n_vec++; if ({data_out, selector} !== 3'b110) begin n_err++; $display("FAIL bp_resume: d/sel=%b/%b want 11/0", data_out, selector); end
      end
      if (k == 8) begin
        n_vec++; if ({data_out, selector} !== 3'b001) begin n_err++; $display("FAIL bp_burst_end: d/sel=%b/%b want 00/1", data_out, selector); end
      end
      if (k == 9) begin
        n_vec++; if (data_out !== 2'b11) begin n_err++; $display("FAIL bp_other: got %b want 11", data_out); end
      end
      if (k == 3) ready_in = 1'b0;
      if (k == 6) ready_in = 1'b1;
    end
    step(); step(); step();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d beats missing, want 0", exp_q.size()); end
  endtask

  task automatic test_early_release();
    src1.push_back(2'b10); src1.push_back(2'b11);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 1) begin src0.push_back(2'b01); src0.push_back(2'b01); end
      if (k == 3) begin
        n_vec++; if ({data_out, selector} !== 3'b111) begin n_err++; $display("FAIL early_last1: d/sel=%b/%b want 11/1", data_out, selector); end
      end
      if (k == 4) begin
        n_vec++; if ({selector, busy, ready_out0} !== 3'b011) begin n_err++; $display("FAIL early_grant0: sel/busy/rdy0=%b%b%b want 011", selector, busy, ready_out0); end
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL early_gap: valid_out=%b want 0", valid_out); end
      end
      if (k == 5) begin
        n_vec++; if ({valid_out, data_out} !== 3'b101) begin n_err++; $display("FAIL early_data0: v/d=%b/%b want 1/01", valid_out, data_out); end
      end
    end
    step(); step(); step();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL early_drain: %0d beats missing, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int b = 0; b < 2 * MB; b++) begin src0.push_back(2'b01); src1.push_back(2'b10); end
    for (int b = 0; b < MB; b++) exp_q.push_back(2'b01);
    step(); step(); step(); step();
    n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL mid_active: valid_out=%b want 1", valid_out); end
    reset = 1'b1;
    src0.delete(); src1.delete(); exp_q.delete();
    step();
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL mid_drop: valid_out=%b want 0", valid_out); end
    n_vec++; if ({ready_out0, ready_out1, selector, busy} !== 4'b0000) begin n_err++; $display("FAIL mid_ctrl: rdy/sel/busy=%b%b%b%b want 0000", ready_out0, ready_out1, selector, busy); end
    step();
    reset = 1'b0;
`ifdef MUX2_1_ARB_STATS_EN
    n_vec++; if ({grant_cnt0, grant_cnt1} !== {CW{2'b00}}) begin n_err++; $display("FAIL mid_stats_reset: got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
`endif
    src0.push_back(2'b11); src0.push_back(2'b11);
    src1.push_back(2'b00); src1.push_back(2'b00);
    exp_q.push_back(2'b11); exp_q.push_back(2'b11);
    exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    step(); step();
    n_vec++; if ({busy, selector} !== 2'b10) begin n_err++; $display("FAIL mid_regrant: busy/sel=%b%b want 10", busy, selector); end
    for (int k = 0; k < 8; k++) step();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: %0d beats missing, want 0", exp_q.size()); end
`ifdef MUX2_1_ARB_STATS_EN
    n_vec++; if ({grant_cnt0, grant_cnt1} !== {8'd1, 8'd1}) begin n_err++; $display("FAIL mid_stats_rotation: got %0d/%0d want 1/1", grant_cnt0, grant_cnt1); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    ready_in = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
